// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB LED PWM controller.
// Contents:
//   mode_e    per-channel operating mode
//   state_e   driver enable sequencer state
//   Sel*      cfg_sel register selectors
//   BlinkW    width of the per-channel blink period counter
package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        ModeOff     = 2'd0,
        ModeStatic  = 2'd1,
        ModeBreathe = 2'd2,
        ModeBlink   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StRun    = 2'd2
    } state_e;

    localparam logic [1:0] SelDuty = 2'd0;
    localparam logic [1:0] SelMode = 2'd1;
    localparam logic [1:0] SelCur  = 2'd2;
    localparam logic [1:0] SelRsvd = 2'd3;

    // Blink spends 2**BlinkW periods lit, then 2**BlinkW periods dark.
    localparam int unsigned BlinkW = 7;

endpackage

// File: rtl/rgb_pwm_ctrl_if.sv
// Configuration write bus for rgb_pwm_ctrl.
// Signals:
//   cfg_we     one-cycle write strobe
//   cfg_ch     target channel (out-of-range channels are ignored)
//   cfg_sel    register select (duty / mode / current / reserved)
//   cfg_wdata  LSB-aligned write data
// Modports: master drives the bus, slave (the controller) samples it.
interface rgb_pwm_ctrl_if #(
    parameter int unsigned PWM_W = 8
);
    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [1:0]       cfg_sel;
    logic [PWM_W-1:0] cfg_wdata;

    modport master (output cfg_we, output cfg_ch, output cfg_sel, output cfg_wdata);
    modport slave  (input cfg_we, input cfg_ch, input cfg_sel, input cfg_wdata);
endinterface

// File: rtl/rgb_pwm_chan.sv
// One LED channel: live config registers, period shadows, breathe/blink
// animation state and the registered PWM comparator.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   we          write strobe already decoded for this channel
//   sel, wdata  register select and data from the config bus
//   load        period wrap: shadows load, animation advances
//   start       entry into RUN: shadows load, animation restarts
//   gate        PWM allowed this cycle (sequencer in RUN and still enabled)
//   pc          shared period counter
//   mode_on     live mode is not OFF
//   pwm         registered gate output
//   cur         live current-trim code
module rgb_pwm_chan
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PWM_W = 8,
    parameter int unsigned CUR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [1:0]       sel,
    input  logic [PWM_W-1:0] wdata,
    input  logic             load,
    input  logic             start,
    input  logic             gate,
    input  logic [PWM_W-1:0] pc,
    output logic             mode_on,
    output logic             pwm,
    output logic [CUR_W-1:0] cur
);
    logic [PWM_W-1:0]  duty_q, duty_d, sh_duty_q, lvl;
    mode_e             mode_q, mode_d, sh_mode_q;
    logic [CUR_W-1:0]  cur_q, cur_d;
    logic              pend_q, anim_rst;
    logic [PWM_W-1:0]  br_q, br_d;
    logic              br_down_q, br_down_d;
    logic [BlinkW-1:0] bl_cnt_q;
    logic              bl_dark_q, pwm_q;

    always_comb begin
        duty_d = duty_q;
        mode_d = mode_q;
        cur_d  = cur_q;
        if (we) begin
            case (sel)
                SelDuty: duty_d = wdata;
                SelMode: mode_d = mode_e'(wdata[1:0]);
                SelCur:  cur_d  = CUR_W'(wdata);
                default: ;
            endcase
        end
    end

    // A mode change, even one coincident with the load, restarts the animation.
    assign anim_rst = start | pend_q | (mode_d != mode_q);

    // Triangle ramp against the duty being loaded; flips direction at 0 and D.
    always_comb begin
        br_d      = br_q;
        br_down_d = br_down_q;
        if (!br_down_q) begin
            if (br_q >= duty_d) begin
                br_down_d = 1'b1;
                br_d      = (br_q == '0) ? '0 : br_q - 1'b1;
            end else begin
                br_d = br_q + 1'b1;
            end
        end else if (br_q == '0) begin
            br_down_d = 1'b0;
            br_d      = (duty_d != '0) ? PWM_W'(1) : '0;
        end else begin
            br_d = br_q - 1'b1;
        end
    end

    always_comb begin
        lvl = '0;
        case (sh_mode_q)
            ModeStatic:  lvl = sh_duty_q;
            ModeBreathe: lvl = (br_q > sh_duty_q) ? sh_duty_q : br_q;
            ModeBlink:   lvl = bl_dark_q ? '0 : sh_duty_q;
            default:     lvl = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q    <= '0;
            mode_q    <= ModeOff;
            cur_q     <= '0;
            sh_duty_q <= '0;
            sh_mode_q <= ModeOff;
            pend_q    <= 1'b0;
            br_q      <= '0;
            br_down_q <= 1'b0;
            bl_cnt_q  <= '0;
            bl_dark_q <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            duty_q <= duty_d;
            mode_q <= mode_d;
            cur_q  <= cur_d;
            pwm_q  <= gate & ((pc < lvl) | (lvl == '1));
            if (load | start) begin
                sh_duty_q <= duty_d;
                sh_mode_q <= mode_d;
                pend_q    <= 1'b0;
                if (anim_rst) begin
                    br_q      <= '0;
                    br_down_q <= 1'b0;
                    bl_cnt_q  <= '0;
                    bl_dark_q <= 1'b0;
                end else begin
                    br_q      <= br_d;
                    br_down_q <= br_down_d;
                    bl_cnt_q  <= bl_cnt_q + 1'b1;
                    if (bl_cnt_q == '1) bl_dark_q <= ~bl_dark_q;
                end
            end else if (mode_d != mode_q) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign mode_on = (mode_q != ModeOff);
    assign pwm     = pwm_q;
    assign cur     = cur_q;
endmodule

// File: rtl/rgb_pwm_ctrl.sv
// N-channel LED PWM controller top: driver-enable sequencer, prescaler,
// period counter and config decode; per-channel logic lives in rgb_pwm_chan.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   glb_en       global LED enable (level)
//   prescale     period counter ticks every prescale+1 clocks
//   cfg          config write bus (slave)
//   pwm_out      per-channel PWM gate
//   cur_code     per-channel current trim, channel i at [i*CUR_W +: CUR_W]
//   rgbled_en    analog driver enable (SETTLE and RUN)
//   period_end   one-cycle pulse on the tick where the period counter wraps
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned NCH        = 3,
    parameter int unsigned PWM_W      = 8,
    parameter int unsigned CUR_W      = 6,
    parameter int unsigned PRE_W      = 16,
    parameter int unsigned SETTLE_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 glb_en,
    input  logic [PRE_W-1:0]     prescale,
    rgb_pwm_ctrl_if.slave        cfg,
    output logic [NCH-1:0]       pwm_out,
    output logic [NCH*CUR_W-1:0] cur_code,
    output logic                 rgbled_en,
    output logic                 period_end
);
    localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);

    state_e           state_q;
    logic [SetW-1:0]  settle_q;
    logic [PRE_W-1:0] presc_q;
    logic [PWM_W-1:0] pc_q;
    logic [NCH-1:0]   mode_on;
    logic             run_ok, active, tick, wrap, start;

    assign run_ok = glb_en & (|mode_on);
    // Gating on run_ok drops PWM on the same edge the sequencer leaves RUN.
    assign active = (state_q == StRun) & run_ok;
    // >= keeps the prescaler from running away if prescale shrinks mid-count.
    assign tick   = active & (presc_q >= prescale);
    assign wrap   = tick & (pc_q == '1);
    assign start  = (state_q == StSettle) & run_ok & (settle_q == SetW'(SETTLE_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            settle_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    settle_q <= '0;
                    if (run_ok) state_q <= StSettle;
                end
                StSettle: begin
                    if (!run_ok)    state_q  <= StIdle;
                    else if (start) state_q  <= StRun;
                    else            settle_q <= settle_q + 1'b1;
                end
                StRun: if (!run_ok) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            pc_q    <= '0;
        end else if (!active) begin
            presc_q <= '0;
            pc_q    <= '0;
        end else if (tick) begin
            presc_q <= '0;
            pc_q    <= pc_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        rgb_pwm_chan #(
            .PWM_W (PWM_W),
            .CUR_W (CUR_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (cfg.cfg_we && (cfg.cfg_ch == 3'(i))),
            .sel     (cfg.cfg_sel),
            .wdata   (cfg.cfg_wdata),
            .load    (wrap),
            .start   (start),
            .gate    (active),
            .pc      (pc_q),
            .mode_on (mode_on[i]),
            .pwm     (pwm_out[i]),
            .cur     (cur_code[i*CUR_W +: CUR_W])
        );
    end

    assign rgbled_en  = (state_q != StIdle);
    assign period_end = wrap;
endmodule
